// File: rtl/lock_key_pkg.sv
// Shared types and constants for the c432 key loader: FSM states, CRC-8 parameters and key-field layout.
package lock_key_pkg;

  typedef enum logic [2:0] {
    IDLE, KEY, CRC, CHECK, ARMED, FAIL, LOCKOUT
  } state_t;

  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT = 8'h00;

  localparam int X_LSB = 0;
  localparam int X_MSB = 14;
  localparam int P_LSB = 15;
  localparam int P_MSB = 18;

  // One MSB-first CRC-8 step, no reflection.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/lock_crc8_serial.sv
// Bit-serial CRC-8 accumulator; clr restarts from CRC_INIT and may coincide with en to fold in the first bit.
module lock_crc8_serial
  import lock_key_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc8_step(clr ? CRC_INIT : crc, din);
    end else if (clr) begin
      crc <= CRC_INIT;
    end
  end

endmodule

// File: rtl/lock_key_loader.sv
// Serial key loader for the locked c432 core: receives key + CRC-8, arms the key bus on a
// passing check, counts failed frames and locks out permanently after MAX_FAIL failures.
//
//   state   | meaning
//   IDLE    | waiting for first beat of a frame
//   KEY     | shifting key bits, updating running CRC
//   CRC     | shifting received CRC bits
//   CHECK   | compare CRC and framing (1 cycle)
//   ARMED   | key bus driven, key_valid high until key_clear
//   FAIL    | err pulse, fail_cnt increment (1 cycle)
//   LOCKOUT | terminal, only rst exits
module lock_key_loader
  import lock_key_pkg::*;
#(
  parameter int KEY_W    = 19,
  parameter int CRC_W    = 8,
  parameter int MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_bit,
  input  logic             s_last,
  input  logic             key_clear,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             err,
  output logic             lockout,
  output logic [3:0]       fail_cnt
);

  localparam int TOTAL = KEY_W + CRC_W;
  localparam int CW    = $clog2(TOTAL + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    rem;        // beats still to come in the current frame
  logic [KEY_W-1:0] key_sr;
  logic [7:0]       crc_rx;
  logic [7:0]       crc_calc;
  logic             frame_bad;
  logic             beat;
  logic             final_beat;
  logic             pass;
  logic [3:0]       fail_next;

  assign beat       = s_valid && s_ready;
  assign final_beat = (state == CRC) && (rem == CW'(1));
  assign pass       = (crc_calc == crc_rx) && !frame_bad;
  assign fail_next  = (fail_cnt == 4'hF) ? 4'hF : fail_cnt + 4'd1;

  assign key_valid = (state == ARMED);
  assign err       = (state == FAIL);
  assign lockout   = (state == LOCKOUT);

  lock_crc8_serial u_crc (
    .clk (clk),
    .rst (rst),
    .clr (beat && (state == IDLE)),
    .en  (beat && ((state == IDLE) || (state == KEY))),
    .din (s_bit),
    .crc (crc_calc)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (beat) state_nxt = s_last ? CHECK : KEY;
      KEY: begin
        if (beat) begin
          if (s_last)                       state_nxt = CHECK;
          else if (rem == CW'(CRC_W + 1))   state_nxt = CRC;
        end
      end
      CRC:     if (beat && (s_last || final_beat)) state_nxt = CHECK;
      CHECK:   state_nxt = pass ? ARMED : FAIL;
      ARMED:   if (key_clear) state_nxt = IDLE;
      FAIL:    state_nxt = (fail_next >= 4'(MAX_FAIL)) ? LOCKOUT : IDLE;
      LOCKOUT: state_nxt = LOCKOUT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s_ready   <= 1'b0;
      key_out   <= '0;
      fail_cnt  <= '0;
      rem       <= '0;
      key_sr    <= '0;
      crc_rx    <= '0;
      frame_bad <= 1'b0;
    end else begin
      state   <= state_nxt;
      s_ready <= (state_nxt == IDLE) || (state_nxt == KEY) || (state_nxt == CRC);
      // Bus only carries a checked key; anything else forces zero.
      key_out <= (state_nxt == ARMED) ? {key_sr[P_MSB:P_LSB], key_sr[X_MSB:X_LSB]} : '0;
      if (state == FAIL) fail_cnt <= fail_next;
      if (beat) begin
        frame_bad <= (s_last != final_beat);
        if (state == IDLE) begin
          key_sr <= KEY_W'(s_bit);
          crc_rx <= '0;
          rem    <= CW'(TOTAL - 1);
        end else begin
          rem <= rem - CW'(1);
          if (state == KEY) key_sr <= {key_sr[KEY_W-2:0], s_bit};
          else              crc_rx <= {crc_rx[6:0], s_bit};
        end
      end
    end
  end

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed bench for lock_key_loader: arming, CRC and framing failures, lockout, clear and reset.
module tb_lock_key_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_bit = 1'b0;
  logic        s_last = 1'b0;
  logic        key_clear = 1'b0;
  logic [18:0] key_out;
  logic        key_valid;
  logic        err;
  logic        lockout;
  logic [3:0]  fail_cnt;

  int tests = 0;
  int fails = 0;

  lock_key_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_bit(s_bit),
    .s_last(s_last), .key_clear(key_clear), .key_out(key_out), .key_valid(key_valid),
    .err(err), .lockout(lockout), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; key_clear = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic send_beat(input logic b, input logic l);
    int n = 0;
    s_valid = 1'b1; s_bit = b; s_last = l;
    while (!s_ready && n < 20) begin tick(); n++; end
    if (!s_ready) begin
      tests++; fails++;
      $display("FAIL beat_timeout: s_ready got %b want 1 within 20 cycles", s_ready);
    end
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Sends beats 1..nbeats of key-then-crc, s_last on beat last_pos (0 = never).
  task automatic send_frame(input logic [18:0] key, input logic [7:0] crc,
                            input int last_pos, input int nbeats, input bit gaps);
    logic b;
    for (int i = 1; i <= nbeats; i++) begin
      b = (i <= 19) ? key[19-i] : crc[27-i];
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send_beat(b, i == last_pos);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
    tests++; if (key_out !== 19'h0) begin fails++; $display("FAIL reset_key_out got %h want 0", key_out); end
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_key_valid got %b want 0", key_valid); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
    tests++; if (lockout !== 1'b0) begin fails++; $display("FAIL reset_lockout got %b want 0", lockout); end
    tests++; if (fail_cnt !== 4'd0) begin fails++; $display("FAIL reset_fail_cnt got %0d want 0", fail_cnt); end
  endtask

  task automatic test_arm();
    logic [18:0] keys [3] = '{19'h00000, 19'h00001, 19'h00002};
    logic [7:0]  crcs [3] = '{8'h00, 8'h07, 8'h0E};
    for (int i = 0; i < 3; i++) begin
      send_frame(keys[i], crcs[i], 27, 27, 1'b0);
      tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL arm%0d_check_cycle key_valid got %b want 0", i, key_valid); end
      tick();
      tests++; if (key_valid !== 1'b1) begin fails++; $display("FAIL arm%0d_key_valid got %b want 1", i, key_valid); end
      tests++; if (key_out !== keys[i]) begin fails++; $display("FAIL arm%0d_key_out got %h want %h", i, key_out, keys[i]); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL arm%0d_err got %b want 0", i, err); end
      key_clear = 1'b1; tick(); key_clear = 1'b0;
    end
  endtask

  task automatic test_bad_crc();
    do_reset();
    send_frame(19'h00001, 8'h06, 27, 27, 1'b0);
    tick();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL badcrc_err got %b want 1", err); end
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL badcrc_key_valid got %b want 0", key_valid); end
    tick();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL badcrc_err_pulse got %b want 0", err); end
    tests++; if (fail_cnt !== 4'd1) begin fails++; $display("FAIL badcrc_fail_cnt got %0d want 1", fail_cnt); end
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL badcrc_s_ready got %b want 1", s_ready); end
    tests++; if (key_out !== 19'h0) begin fails++; $display("FAIL badcrc_key_out got %h want 0", key_out); end
  endtask

  task automatic test_framing();
    do_reset();
    send_frame(19'h00001, 8'h07, 10, 10, 1'b0);
    tick();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL early_last_err got %b want 1", err); end
    tick();
    tests++; if (fail_cnt !== 4'd1) begin fails++; $display("FAIL early_last_fail_cnt got %0d want 1", fail_cnt); end
    send_frame(19'h00001, 8'h07, 0, 27, 1'b0);
    tick();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL no_last_err got %b want 1", err); end
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL no_last_key_valid got %b want 0", key_valid); end
    tick();
    tests++; if (fail_cnt !== 4'd2) begin fails++; $display("FAIL no_last_fail_cnt got %0d want 2", fail_cnt); end
    tests++; if (lockout !== 1'b0) begin fails++; $display("FAIL no_last_lockout got %b want 0", lockout); end
  endtask

  task automatic test_gaps_and_clear();
    do_reset();
    send_frame(19'h40000, 8'hAB, 27, 27, 1'b1);
    tick();
    tests++; if (key_valid !== 1'b1) begin fails++; $display("FAIL gaps_key_valid got %b want 1", key_valid); end
    tests++; if (key_out !== 19'h40000) begin fails++; $display("FAIL gaps_key_out got %h want 40000", key_out); end
    key_clear = 1'b1; tick(); key_clear = 1'b0;
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL clear_key_valid got %b want 0", key_valid); end
    tests++; if (key_out !== 19'h0) begin fails++; $display("FAIL clear_key_out got %h want 0", key_out); end
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL clear_s_ready got %b want 1", s_ready); end
  endtask

  task automatic test_lockout();
    do_reset();
    for (int f = 0; f < 3; f++) begin
      send_frame(19'h00001, 8'h06, 27, 27, 1'b0);
      tick(); tick();
    end
    tests++; if (fail_cnt !== 4'd3) begin fails++; $display("FAIL lockout_fail_cnt got %0d want 3", fail_cnt); end
    tests++; if (lockout !== 1'b1) begin fails++; $display("FAIL lockout_flag got %b want 1", lockout); end
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL lockout_s_ready got %b want 0", s_ready); end
    for (int i = 1; i <= 27; i++) begin
      s_valid = 1'b1; s_bit = (i == 19); s_last = (i == 27);
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    tick(); tick();
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL lockout_ignore_key_valid got %b want 0", key_valid); end
    tests++; if (lockout !== 1'b1) begin fails++; $display("FAIL lockout_ignore_flag got %b want 1", lockout); end
    tests++; if (fail_cnt !== 4'd3) begin fails++; $display("FAIL lockout_ignore_fail_cnt got %0d want 3", fail_cnt); end
    rst = 1'b1; tick();
    tests++; if (lockout !== 1'b0) begin fails++; $display("FAIL lockout_rst_flag got %b want 0", lockout); end
    tests++; if (fail_cnt !== 4'd0) begin fails++; $display("FAIL lockout_rst_fail_cnt got %0d want 0", fail_cnt); end
    rst = 1'b0; tick();
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL lockout_rst_s_ready got %b want 1", s_ready); end
  endtask

  task automatic test_mid_key_reset();
    do_reset();
    send_frame(19'h00002, 8'h0E, 0, 10, 1'b0);
    rst = 1'b1; tick();
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL midrst_s_ready got %b want 0", s_ready); end
    tests++; if (key_out !== 19'h0 || key_valid !== 1'b0 || err !== 1'b0)
      begin fails++; $display("FAIL midrst_outputs got %h/%b/%b want 0/0/0", key_out, key_valid, err); end
    rst = 1'b0;
    send_frame(19'h00002, 8'h0E, 27, 27, 1'b0);
    tick();
    tests++; if (key_valid !== 1'b1) begin fails++; $display("FAIL midrst_rearm_key_valid got %b want 1", key_valid); end
    tests++; if (key_out !== 19'h00002) begin fails++; $display("FAIL midrst_rearm_key_out got %h want 00002", key_out); end
  endtask

  task automatic test_armed_ignores_beats();
    s_valid = 1'b1; s_bit = 1'b1; s_last = 1'b1;
    repeat (5) tick();
    s_valid = 1'b0; s_last = 1'b0;
    tests++; if (key_out !== 19'h00002) begin fails++; $display("FAIL armed_hold_key_out got %h want 00002", key_out); end
    tests++; if (key_valid !== 1'b1) begin fails++; $display("FAIL armed_hold_key_valid got %b want 1", key_valid); end
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL armed_hold_s_ready got %b want 0", s_ready); end
    key_clear = 1'b1; tick(); key_clear = 1'b0;
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL armed_clear_key_valid got %b want 0", key_valid); end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_bad_crc();
    test_framing();
    test_gaps_and_clear();
    test_lockout();
    test_mid_key_reset();
    test_armed_ignores_beats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lock_key_loader.md
Name: lock_key_loader

Overview:
- Serial key-delivery front end for the locked c432 netlists: the unlocking side of the XOR/MUX key-gate interface.
- Receives a key bitstream followed by a CRC-8 over a ready/valid serial link, and checks it.
- On a passing check, drives the key bus that feeds the locked core's X_* XOR keys and p* MUX4 keys.
- Holds the key bus at zero unless armed; counts failed loads and locks out after too many.

Parameters:
- KEY_W, 19, key width; bits [14:0] drive X_1..X_15 (bit0=X_1), bits [18:15] drive p1..p4 (bit15=p1).
- CRC_W, 8, checksum width (fixed CRC-8, poly 0x07, init 0x00, MSB-first, no reflection, no final XOR).
- MAX_FAIL, 3, failed loads before permanent lockout (range 1..15).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  serial beat valid.
- s_ready  out  1  loader can accept a beat.
- s_bit  in  1  serial data bit.
- s_last  in  1  marks final beat of frame (last CRC bit).
- key_clear  in  1  drop armed key, return to IDLE.
- key_out  out  KEY_W  key bus to the locked core; zero unless ARMED.
- key_valid  out  1  high only in ARMED.
- err  out  1  one-cycle pulse per failed frame.
- lockout  out  1  high in LOCKOUT.
- fail_cnt  out  4  failed frames since reset.

Behaviour:
- Reset values: s_ready=0, key_out=0, key_valid=0, err=0, lockout=0, fail_cnt=0; state=IDLE. Reset mid-frame discards all partial data.
- Beat accepted when s_valid && s_ready. s_ready=1 in IDLE, KEY and CRC; 0 in CHECK, ARMED, LOCKOUT.
- States:
  - IDLE: first accepted beat goes to the key shift register, and the state moves to KEY.
  - KEY: beats shift in MSB first; the first beat is key bit KEY_W-1. The running CRC updates on every key bit. After beat KEY_W the state moves to CRC.
  - CRC: the next CRC_W beats shift into a received-CRC register, MSB first. After the last of them the state moves to CHECK.
  - CHECK (1 cycle): pass iff received CRC equals computed CRC and framing is correct. Pass -> ARMED. Fail -> FAIL.
  - ARMED: key_out is loaded on entry, so it is visible the cycle after CHECK; key_valid=1. key_clear -> IDLE, and key_out and key_valid are zeroed on the next cycle.
  - FAIL (1 cycle): err=1, fail_cnt++. If the new count is >= MAX_FAIL -> LOCKOUT, else -> IDLE. key_out stays 0.
  - LOCKOUT: lockout=1; all inputs ignored; exit only via rst.
- Latency: final beat accepted in cycle t -> CHECK at t+1 -> key_valid/key_out or err asserted at t+2.
- Framing error (counts as a CRC failure):
  - s_last high on any beat other than beat KEY_W+CRC_W;
  - s_last low on beat KEY_W+CRC_W.
  - An early s_last goes to CHECK immediately and fails there.
- CRC update per key bit: fb = crc[7]^bit; crc = crc<<1; if fb, crc ^= 0x07.
- key_clear is ignored outside ARMED. Simultaneous rst and anything else: rst wins.
- s_valid while s_ready=0: the beat is not consumed and there is no side effect.
- fail_cnt saturates at 15 and never wraps. The shift register is loaded only while s_ready is high; key_out never reflects partial data.

Decomposition:
- Shared package lock_key_pkg holds:
  - the state enum (IDLE, KEY, CRC, CHECK, ARMED, FAIL, LOCKOUT);
  - CRC_POLY=8'h07 and CRC_INIT=8'h00;
  - key-field index constants X_LSB=0, X_MSB=14, P_LSB=15, P_MSB=18.
- One sub-module, lock_crc8_serial, does the bit-serial CRC update with clear and enable.

Test Plan:
- Zero key 19'h00000, CRC 0x00, s_last on beat 27 -> key_valid=1 and key_out=0 two cycles after beat 27; err=0.
- Key 19'h00001 with CRC 0x07 -> armed, key_out=19'h00001 (X_1=1). Key 19'h00002 with CRC 0x0E -> armed, key_out=19'h00002.
- Key 19'h00001 with CRC 0x06 -> err pulse once, fail_cnt=1, key_valid=0, s_ready=1 again the cycle after FAIL.
- Three bad frames in a row -> fail_cnt=3, lockout=1, s_ready=0. A subsequent valid frame is ignored. rst clears everything to reset values.
- Framing errors:
  - s_last on beat 10 -> fail, fail_cnt=1.
  - 27 beats with no s_last -> fail.
  - s_valid toggled randomly mid-frame with a correct frame -> armed.
- Armed then key_clear -> key_out=0 and key_valid=0 next cycle, state IDLE. rst asserted mid-KEY -> all outputs 0, and the next full correct frame arms.
